// File: rtl/uart_wb_pkg.sv
// rtl/uart_wb_pkg.sv - shared UART/Wishbone constants and arbiter state type
package uart_wb_pkg;

    localparam int         UART_FIFO_COUNTER_W = 5;
    localparam logic [7:0] UART_ARB_EOL        = 8'h0A;
    localparam int         UART_ARB_TIMEOUT    = 1024;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - first set request at or after a pointer, wrapping
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW:0] sum;

    // Scan from the farthest candidate down so the nearest one at/after ptr_i wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            if (req_i[sum[IW-1:0]]) begin
                idx_o   = sum[IW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - line-granular round-robin arbiter feeding the UART TX FIFO
module uart_tx_arbiter
    import uart_wb_pkg::*;
#(
    parameter int         NREQ       = 4,
    parameter int         FIFO_DEPTH = 16,
    parameter int         CNT_W      = UART_FIFO_COUNTER_W,
    parameter logic [7:0] EOL_CHAR   = UART_ARB_EOL,
    parameter int         TIMEOUT    = UART_ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   gnt,
    input  logic [CNT_W-1:0]  tf_count,
    input  logic              tx_reset,
    output logic              tf_push,
    output logic [7:0]        tf_data,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          tf_push_q, tf_push_d;
    logic [7:0]    tf_data_q, tf_data_d;

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          locked;
    logic          space;
    logic          owner_valid;
    logic [7:0]    owner_byte;
    logic          accept;
    logic          timed_out;
    logic          line_done;
    logic [IW-1:0] ptr_after_owner;

    uart_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // The byte pushed last cycle is not yet in tf_count, so it is added in.
    assign space = ({1'b0, tf_count} + {{CNT_W{1'b0}}, tf_push_q}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign locked          = (state_q == LOCKED);
    assign owner_valid     = req_valid[owner_q];
    assign owner_byte      = req_data[{owner_q, 3'b000} +: 8];
    assign accept          = locked & ~tx_reset & space & owner_valid;
    assign timed_out       = locked & ~owner_valid & (idle_cnt_q == TW'(TIMEOUT - 1));
    assign line_done       = (accept & (owner_byte == EOL_CHAR)) | timed_out;
    assign ptr_after_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // State register.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush beats everything, otherwise lock on a request and unlock at line end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found && !tx_reset) state_d = LOCKED;
            LOCKED:  if (tx_reset || line_done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the owner may see ready, and never during a flush.
    always_comb begin
        gnt       = locked ? (NREQ'(1) << owner_q) : '0;
        req_ready = (locked && space && !tx_reset) ? (NREQ'(1) << owner_q) : '0;
        busy      = locked | tf_push_q;
    end

    // Datapath next values: owner capture, fairness pointer, idle timer, push register.
    always_comb begin
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        tf_push_d  = accept;
        tf_data_d  = tf_data_q;
        if (accept) begin
            tf_data_d = owner_byte;
        end
        if (!locked && pick_found && !tx_reset) begin
            owner_d    = pick_idx;
            idle_cnt_d = '0;
        end
        if (locked) begin
            if (tx_reset || line_done) begin
                rr_ptr_d   = ptr_after_owner;
                idle_cnt_d = '0;
            end else if (accept) begin
                idle_cnt_d = '0;
            end else if (!owner_valid) begin
                idle_cnt_d = idle_cnt_q + TW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            tf_push_q  <= 1'b0;
            tf_data_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            tf_push_q  <= tf_push_d;
            tf_data_q  <= tf_data_d;
        end
    end

    assign tf_push = tf_push_q;
    assign tf_data = tf_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter FIFO push port among N character-stream requesters, e.g. per-core debug consoles.
- Arbitration is round-robin at line granularity. A granted requester keeps ownership until it sends the line terminator or goes idle past a timeout, so lines from different requesters never interleave.
- Drives the transmitter's tf_push/wb_dat_i and throttles on its tf_count so the 16-entry TX FIFO never overruns.

Parameters:
- NREQ, 4, number of requesters (2..8)
- FIFO_DEPTH, 16, TX FIFO depth; must match the transmitter FIFO
- CNT_W, 5, width of tf_count (UART_FIFO_COUNTER_W)
- EOL_CHAR, 8'h0A, byte that ends a line and releases the lock
- TIMEOUT, 1024, idle cycles of the owner before forced release (>=2)

Ports:
- clk  in  1  clock
- wb_rst_i  in  1  reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_ready  out  NREQ  per-requester accept; byte transfers when valid&ready
- gnt  out  NREQ  one-hot current owner; all-zero when unlocked
- tf_count  in  CNT_W  TX FIFO occupancy from transmitter
- tx_reset  in  1  TX FIFO flush (same pulse the transmitter receives)
- tf_push  out  1  registered FIFO push, 1-cycle pulse per byte
- tf_data  out  8  registered byte; connects to transmitter wb_dat_i
- busy  out  1  lock held or push in flight

Behaviour:
- Clock and reset: reset wb_rst_i, asynchronous, active-high; clock clk.
- Reset values: gnt=0, req_ready=0, tf_push=0, tf_data=0, busy=0, rr_ptr=0, idle_cnt=0, state=IDLE.
- Space check: space = (tf_count + tf_push) < FIFO_DEPTH. tf_push counts because the FIFO has not yet sampled the byte issued last cycle. The sum is computed CNT_W+1 bits wide.
- FSM state IDLE:
  - If any req_valid is set, pick the first requester at or after rr_ptr (wrapping modulo NREQ).
  - Set gnt to that requester, clear idle_cnt, go to LOCKED. Arbitration takes 1 cycle.
  - No byte is accepted in IDLE.
- FSM state LOCKED:
  - req_ready[g] = space, combinational; all other req_ready are 0.
  - On valid&ready: tf_push<=1, tf_data<=req_data[g], idle_cnt<=0. Otherwise tf_push<=0.
  - If the accepted byte == EOL_CHAR: release, rr_ptr<=(g+1) mod NREQ, go to IDLE, gnt<=0 next cycle.
  - When the owner has no valid: idle_cnt increments. At idle_cnt==TIMEOUT-1, release the same way as EOL.
  - A stall for FIFO space with valid high does not count as idle.
- Maximum throughput is 1 byte per cycle while space holds.
- Full boundary: at tf_count==FIFO_DEPTH-1 with tf_push=1, ready=0. A lag-induced overrun is impossible.
- tx_reset:
  - Same cycle: ready forced 0 and tf_push<=0.
  - Next edge: lock released, rr_ptr advanced past the owner, state IDLE.
  - The byte in flight that cycle is dropped, since the FIFO is being flushed.
- Simultaneous events:
  - EOL accept and timeout in the same cycle count as one release.
  - tx_reset has priority over everything.
  - A requester dropping valid while not granted has no effect.
- Reset mid-line: everything returns to reset values immediately; any partial line is lost.
- busy = (state==LOCKED) | tf_push.

Decomposition:
- Shared package uart_wb_pkg:
  - UART_FIFO_COUNTER_W (reused)
  - state typedef (IDLE, LOCKED)
  - default EOL and TIMEOUT constants
- One sub-module: uart_rr_pick. It is combinational and finds the first set bit at or after a pointer with wrap, returning index and found.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Single requester: req0 sends "AB\n" with tf_count=0 → gnt=0001 one cycle after valid; tf_push on 3 consecutive cycles with tf_data 41,42,0A; gnt=0 after 0A; rr_ptr=1.
- Line isolation: req0 and req2 both stream "xy\n" from cycle 0 → pushes x,y,0A from req0, then x,y,0A from req2; no interleave; rr_ptr=3 at end.
- Round-robin fairness: all 4 requesters hold valid continuously sending 1-byte lines of 0A → grants in order 0,1,2,3,0; each requester wins 1 of every 4 grants.
- FIFO full: hold tf_count=15 while tf_push=1 → req_ready=0 that cycle; with tf_count=15 and tf_push=0 → exactly one push, then stall until tf_count<16; a bench FIFO model never exceeds 16.
- Timeout: TIMEOUT=8; req1 sends 'a' then drops valid → gnt released exactly 8 cycles after the push cycle; pending req3 is granted next.
- tx_reset mid-line: req0 is mid-line with valid high; pulse tx_reset one cycle → tf_push=0 that cycle; gnt=0 next cycle; req1 is granted before req0 is re-granted.
